lb_regmap_engine: RTL and testbench

//  Parametrised localbus register-map engine: decodes {ctrl,addr,data} commands from a localbus master
//  (UART/UDP bridge) into NREG writable registers plus NREG read-only status words, and returns a response.

---
 rtl/lb_regmap_pkg.sv | 45 ++++
 rtl/lb_resp_fifo.sv | 68 ++++++
 rtl/lb_regmap_engine.sv | 199 +++++++++++++++++++
 tb/tb_lb_regmap_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_regmap_pkg.sv
// lb_regmap_pkg
//   Shared types and helpers for the localbus register-map engine.
//   - LB_*WIDTH : default localbus field widths (UART bridge flavour)
//   - cmd_t     : localbus command {ctrl, addr, data} at the default widths
//   - resp_t    : response word {cmd, err}
//   - dec_t     : address decode result {hit, idx}
//   - lb_decode : maps an address onto a register index inside a window
package lb_regmap_pkg;

  localparam int LB_CWIDTH   = 8;
  localparam int LB_AWIDTH   = 24;
  localparam int LB_DWIDTH   = 32;
  localparam int LB_IDXWIDTH = 8;

  typedef struct packed {
    logic [LB_CWIDTH-1:0] ctrl;
    logic [LB_AWIDTH-1:0] addr;
    logic [LB_DWIDTH-1:0] data;
  } cmd_t;

  typedef struct packed {
    cmd_t cmd;
    logic err;
  } resp_t;

  typedef struct packed {
    logic                   hit;
    logic [LB_IDXWIDTH-1:0] idx;
  } dec_t;

  // Arguments are zero-extended to 64 bits by the caller; the subtraction is
  // done one bit wider so an address below the base can never wrap into the
  // window.
  function automatic dec_t lb_decode(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] nreg);
    dec_t        d;
    logic [64:0] off;
    off   = {1'b0, addr} - {1'b0, base};
    d.hit = (addr >= base) && (off < {1'b0, nreg});
    d.idx = LB_IDXWIDTH'(off);
    return d;
  endfunction

endpackage

// File: rtl/lb_resp_fifo.sv
// lb_resp_fifo
//   First-word-fall-through response queue. The head entry is presented on
//   o_data whenever the queue is non-empty; o_data reads as zero when empty.
//   Push and pop in the same cycle are allowed on a full or empty queue.
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write i_data into the tail
//   i_data    : entry to push
//   i_pop     : consume the head entry (ignored while empty)
//   o_data    : head entry
//   o_empty   : queue holds no entries
//   o_count   : number of entries held
module lb_resp_fifo
  import lb_regmap_pkg::*;
#(
  parameter type T     = resp_t,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  T            i_data,
  input  logic        i_pop,
  output T            o_data,
  output logic        o_empty,
  output logic [AW:0] o_count
);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_doPush;
  logic          w_doPop;

  // DEPTH is a power of two, so the count MSB alone marks a full queue.
  assign w_full   = r_count[AW];
  assign o_empty  = (r_count == '0);
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!w_full || w_doPop);
  assign o_count  = r_count;
  assign o_data   = o_empty ? T'('0) : r_mem[r_rdPtr];

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lb_regmap_engine.sv
// lb_regmap_engine
//   Localbus register-map engine. Decodes {ctrl,addr,data} commands into
//   NREG writable registers and NREG read-only status words, then returns a
//   response through an RDLAT-deep pipeline and a response FIFO.
// Ports
//   clk, rst   : localbus clock, asynchronous active-high reset
//   wcmd       : command {ctrl,addr,data};   wvalid / wready handshake
//   rcmd       : response {ctrl,addr,data};  rready valid, rack consumes
//   rerr       : response flags unmapped address or write to a RO register
//   regs_out   : register contents, reg i at [i*LBDWIDTH +: LBDWIDTH]
//   stb_out    : one-cycle write strobes for STB_MASK registers
//   status_in  : read-only status words, same packing as regs_out
module lb_regmap_engine
  import lb_regmap_pkg::*;
#(
  parameter int                     LBCWIDTH  = LB_CWIDTH,
  parameter int                     LBAWIDTH  = LB_AWIDTH,
  parameter int                     LBDWIDTH  = LB_DWIDTH,
  parameter logic [LBCWIDTH-1:0]    WRITECMD  = LBCWIDTH'(1),
  parameter logic [LBCWIDTH-1:0]    READCMD   = LBCWIDTH'(0),
  parameter int                     NREG      = 16,
  parameter logic [LBAWIDTH-1:0]    BASEADDR  = '0,
  parameter int                     RDLAT     = 2,
  parameter int                     FIFODEPTH = 4,
  parameter logic [NREG-1:0]        RO_MASK   = '0,
  parameter logic [NREG-1:0]        STB_MASK  = '0,
  parameter logic [NREG*LBDWIDTH-1:0] RESETVAL = '0,
  parameter logic [LBDWIDTH-1:0]    DEADVAL   = LBDWIDTH'(32'hdeadbeef)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [LBCWIDTH+LBAWIDTH+LBDWIDTH-1:0] wcmd,
  input  logic                                  wvalid,
  output logic                                  wready,
  output logic [LBCWIDTH+LBAWIDTH+LBDWIDTH-1:0] rcmd,
  output logic                                  rready,
  input  logic                                  rack,
  output logic                                  rerr,
  output logic [NREG*LBDWIDTH-1:0]              regs_out,
  output logic [NREG-1:0]                       stb_out,
  input  logic [NREG*LBDWIDTH-1:0]              status_in
);

  localparam int CNTW = $clog2(FIFODEPTH) + 1;

  // The package types fix the default widths; the engine re-declares them at
  // its own parameter widths and hands the response type to the FIFO.
  typedef struct packed {
    logic [LBCWIDTH-1:0] ctrl;
    logic [LBAWIDTH-1:0] addr;
    logic [LBDWIDTH-1:0] data;
  } lcmd_t;

  typedef struct packed {
    lcmd_t cmd;
    logic  err;
  } lresp_t;

  if (WRITECMD == READCMD) begin : g_badCmd
    $error("lb_regmap_engine: WRITECMD and READCMD must differ");
  end
  if (NREG < 1 || NREG > 256) begin : g_badNreg
    $error("lb_regmap_engine: NREG must be 1..256");
  end
  if (RDLAT < 1) begin : g_badLat
    $error("lb_regmap_engine: RDLAT must be at least 1");
  end
  if (FIFODEPTH < 2 || (FIFODEPTH & (FIFODEPTH - 1)) != 0) begin : g_badDepth
    $error("lb_regmap_engine: FIFODEPTH must be a power of two >= 2");
  end
  if (LBAWIDTH > 63) begin : g_badAw
    $error("lb_regmap_engine: LBAWIDTH must be at most 63");
  end

  lcmd_t               w_cmd;
  dec_t                w_dec;
  logic                w_accept;
  logic                w_isWrite;
  logic                w_isRead;
  logic                w_ro;
  logic [LBDWIDTH-1:0] w_regData;
  logic [LBDWIDTH-1:0] w_statData;
  logic [NREG-1:0]     w_wrEn;
  lresp_t              w_resp;
  int                  w_inFlight;
  lresp_t              w_head;
  logic                w_empty;
  logic [CNTW-1:0]     w_count;
  logic                w_pop;

  logic [LBDWIDTH-1:0] r_regs [NREG];
  logic [NREG-1:0]     r_stb;
  lresp_t              r_pipe [RDLAT];
  logic [RDLAT-1:0]    r_pipeValid;

  assign w_cmd     = lcmd_t'(wcmd);
  assign w_dec     = lb_decode(64'(w_cmd.addr), 64'(BASEADDR), 64'(NREG));
  assign w_isWrite = (w_cmd.ctrl == WRITECMD);
  assign w_isRead  = (w_cmd.ctrl == READCMD);

  // Every pipeline entry will land in the FIFO, so a new command is taken
  // only while the free FIFO slots outnumber the entries still in flight.
  always_comb begin
    w_inFlight = 0;
    for (int k = 0; k < RDLAT; k++) w_inFlight += int'(r_pipeValid[k]);
    wready   = (FIFODEPTH - int'(w_count)) > w_inFlight;
    w_accept = wvalid && wready;
  end

  // Select the addressed register, status word and RO flag by comparing the
  // decoded index against each register number.
  always_comb begin
    w_ro       = 1'b0;
    w_regData  = '0;
    w_statData = '0;
    w_wrEn     = '0;
    for (int i = 0; i < NREG; i++) begin
      if (w_dec.hit && w_dec.idx == LB_IDXWIDTH'(i)) begin
        w_ro       = RO_MASK[i];
        w_regData  = r_regs[i];
        w_statData = status_in[i*LBDWIDTH +: LBDWIDTH];
        w_wrEn[i]  = w_accept && w_isWrite && !RO_MASK[i];
      end
    end
  end

  // Build the response word at accept time; reads capture data right here so
  // a read following a write sees the value written one edge earlier.
  always_comb begin
    w_resp.cmd = w_cmd;
    w_resp.err = 1'b0;
    if (w_isWrite) begin
      w_resp.err = !w_dec.hit || w_ro;
    end else if (w_isRead) begin
      if (!w_dec.hit) begin
        w_resp.cmd.data = DEADVAL;
        w_resp.err      = 1'b1;
      end else begin
        w_resp.cmd.data = w_ro ? w_statData : w_regData;
      end
    end
  end

  // Register file and strobes; a strobe is high only in the cycle after the
  // accepting edge of a successful write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= RESETVAL[i*LBDWIDTH +: LBDWIDTH];
      r_stb <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_wrEn[i]) r_regs[i] <= w_cmd.data;
      end
      r_stb <= w_wrEn & STB_MASK;
    end
  end

  // Response delay line: stage 0 loads at the accept edge, the last stage
  // feeds the FIFO, giving rready RDLAT edges after accept when it is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipeValid <= '0;
      for (int k = 0; k < RDLAT; k++) r_pipe[k] <= '0;
    end else begin
      r_pipeValid[0] <= w_accept;
      r_pipe[0]      <= w_resp;
      for (int k = 1; k < RDLAT; k++) begin
        r_pipeValid[k] <= r_pipeValid[k-1];
        r_pipe[k]      <= r_pipe[k-1];
      end
    end
  end

  assign w_pop = rack && !w_empty;

  lb_resp_fifo #(
    .T     (lresp_t),
    .DEPTH (FIFODEPTH)
  ) u_respFifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_pipeValid[RDLAT-1]),
    .i_data  (r_pipe[RDLAT-1]),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign rready  = !w_empty;
  assign rcmd    = w_head.cmd;
  assign rerr    = w_head.err;
  assign stb_out = r_stb;

  for (genvar g = 0; g < NREG; g++) begin : g_regsOut
    assign regs_out[g*LBDWIDTH +: LBDWIDTH] = r_regs[g];
  end

endmodule

// File: tb/tb_lb_regmap_engine.sv
// tb_lb_regmap_engine
//   Directed bench for lb_regmap_engine with NREG=16, BASEADDR=0, RDLAT=2,
//   FIFODEPTH=4, register 5 read-only and register 2 strobed.
//   Register i resets to 0x1000_0000+i; status word i is 0xA000_0000+i
//   except word 5, which is 0x1234_5678.
module tb_lb_regmap_engine;

  function automatic logic [511:0] mkResetVal();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'h1000_0000 | 32'(i);
    return v;
  endfunction

  localparam logic [511:0] RESETV = mkResetVal();

  logic         clk;
  logic         rst;
  logic [63:0]  wcmd;
  logic         wvalid;
  logic         wready;
  logic [63:0]  rcmd;
  logic         rready;
  logic         rack;
  logic         rerr;
  logic [511:0] regs_out;
  logic [15:0]  stb_out;
  logic [511:0] status_in;

  int           numCompared;
  int           numMismatched;
  logic [31:0]  expRegs [16];

  lb_regmap_engine #(
    .NREG      (16),
    .RDLAT     (2),
    .FIFODEPTH (4),
    .RO_MASK   (16'h0020),
    .STB_MASK  (16'h0004),
    .RESETVAL  (RESETV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wcmd      (wcmd),
    .wvalid    (wvalid),
    .wready    (wready),
    .rcmd      (rcmd),
    .rready    (rready),
    .rack      (rack),
    .rerr      (rerr),
    .regs_out  (regs_out),
    .stb_out   (stb_out),
    .status_in (status_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [511:0] actual,
                             input logic [511:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [511:0] packRegs();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = expRegs[i];
    return v;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 16; i++) expRegs[i] = RESETV[i*32 +: 32];
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after a rising edge; returns one time unit after
  // the edge that accepted the command.
  task automatic applyStimulus(input logic [7:0] c, input logic [23:0] a,
                               input logic [31:0] d);
    int waitCycles = 0;
    wcmd   = {c, a, d};
    wvalid = 1'b1;
    while (!wready && waitCycles < 50) begin
      nextCycle();
      waitCycles++;
    end
    if (!wready) checkOutput("accept_timeout", wready, 1);
    nextCycle();
    wvalid = 1'b0;
    if (c == 8'h01 && a < 24'd16 && a != 24'd5) expRegs[a[3:0]] = d;
  endtask

  task automatic getResponse(input string tag, input logic [63:0] expCmd,
                             input logic expErr);
    int waitCycles = 0;
    while (!rready && waitCycles < 50) begin
      nextCycle();
      waitCycles++;
    end
    checkOutput({tag, "_valid"}, rready, 1);
    checkOutput({tag, "_cmd"}, rcmd, expCmd);
    checkOutput({tag, "_err"}, rerr, expErr);
    rack = 1'b1;
    nextCycle();
    rack = 1'b0;
  endtask

  logic [63:0] rxq [$];
  logic [63:0] expResp [8];
  int          sent;
  int          got;
  logic        canAccept;
  logic        doPop;
  logic        anyErr;

  initial begin
    numCompared   = 0;
    numMismatched = 0;
    rst    = 1'b1;
    wcmd   = '0;
    wvalid = 1'b0;
    rack   = 1'b0;
    for (int i = 0; i < 16; i++) status_in[i*32 +: 32] = 32'hA000_0000 | 32'(i);
    status_in[5*32 +: 32] = 32'h1234_5678;
    resetModel();

    // 1: reset values, then reset in the middle of a write
    #12;
    checkOutput("t1_rst_regs", regs_out, RESETV);
    checkOutput("t1_rst_rready", rready, 0);
    checkOutput("t1_rst_stb", stb_out, 0);
    rst = 1'b0;
    nextCycle();
    checkOutput("t1_wready", wready, 1);
    applyStimulus(8'h01, 24'h000000, 32'hAAAA_5555);
    checkOutput("t1_wr_regs", regs_out, packRegs());
    #3 rst = 1'b1;
    #1;
    checkOutput("t1_midrst_regs", regs_out, RESETV);
    checkOutput("t1_midrst_rready", rready, 0);
    checkOutput("t1_midrst_rcmd", rcmd, 0);
    checkOutput("t1_midrst_rerr", rerr, 0);
    #2 rst = 1'b0;
    resetModel();
    nextCycle();
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("t1_flushed_rready", rready, 0);
    checkOutput("t1_after_wready", wready, 1);

    // 2: write then read back-to-back, with response latency
    applyStimulus(8'h01, 24'h000003, 32'hCAFE_F00D);
    checkOutput("t2_lat0", rready, 0);
    applyStimulus(8'h00, 24'h000003, 32'h0000_0000);
    checkOutput("t2_lat1", rready, 0);
    checkOutput("t2_regs", regs_out, packRegs());
    nextCycle();
    checkOutput("t2_lat2", rready, 1);
    getResponse("t2_wr", 64'h01_000003_CAFEF00D, 1'b0);
    getResponse("t2_rd", 64'h00_000003_CAFEF00D, 1'b0);

    // 3: unmapped addresses, window edges and an unknown ctrl code
    applyStimulus(8'h00, 24'h000020, 32'h0);
    getResponse("t3_rd20", 64'h00_000020_DEADBEEF, 1'b1);
    applyStimulus(8'h00, 24'h000010, 32'h0);
    getResponse("t3_rd10", 64'h00_000010_DEADBEEF, 1'b1);
    applyStimulus(8'h00, 24'h00000F, 32'h0);
    getResponse("t3_rd0f", 64'h00_00000F_1000000F, 1'b0);
    applyStimulus(8'h01, 24'h000020, 32'h1111_2222);
    getResponse("t3_wr20", 64'h01_000020_11112222, 1'b1);
    checkOutput("t3_wr20_regs", regs_out, packRegs());
    applyStimulus(8'h07, 24'h000004, 32'h0BAD_0BAD);
    getResponse("t3_other", 64'h07_000004_0BAD0BAD, 1'b0);
    checkOutput("t3_other_regs", regs_out, packRegs());

    // 4: read-only register 5
    applyStimulus(8'h01, 24'h000005, 32'h0000_0055);
    getResponse("t4_wr5", 64'h01_000005_00000055, 1'b1);
    checkOutput("t4_regs", regs_out, packRegs());
    applyStimulus(8'h00, 24'h000005, 32'h0);
    getResponse("t4_rd5", 64'h00_000005_12345678, 1'b0);

    // 5: strobes on register 2
    applyStimulus(8'h01, 24'h000002, 32'h2222_2222);
    checkOutput("t5_single_on", stb_out, 16'h0004);
    nextCycle();
    checkOutput("t5_single_off", stb_out, 16'h0000);
    applyStimulus(8'h01, 24'h000002, 32'h3333_3333);
    checkOutput("t5_b2b_first", stb_out, 16'h0004);
    applyStimulus(8'h01, 24'h000002, 32'h4444_4444);
    checkOutput("t5_b2b_second", stb_out, 16'h0004);
    applyStimulus(8'h01, 24'h000003, 32'h3535_3535);
    checkOutput("t5_unmasked", stb_out, 16'h0000);
    checkOutput("t5_regs", regs_out, packRegs());
    getResponse("t5_r0", 64'h01_000002_22222222, 1'b0);
    getResponse("t5_r1", 64'h01_000002_33333333, 1'b0);
    getResponse("t5_r2", 64'h01_000002_44444444, 1'b0);
    getResponse("t5_r3", 64'h01_000003_35353535, 1'b0);

    // 6: eight reads against a stalled master, then drain
    for (int i = 0; i < 8; i++)
      expResp[i] = {8'h00, 24'(i), (i == 5) ? 32'h1234_5678 : expRegs[i]};
    sent = 0;
    got  = 0;
    rack = 1'b0;
    for (int cyc = 0; cyc < 40 && sent < 4; cyc++) begin
      wcmd      = {8'h00, 24'(sent), 32'h0};
      wvalid    = 1'b1;
      canAccept = wready;
      nextCycle();
      if (canAccept) sent++;
    end
    checkOutput("t6_wready_drop", wready, 0);
    for (int cyc = 0; cyc < 3; cyc++) begin
      canAccept = wready;
      nextCycle();
      if (canAccept) sent++;
    end
    checkOutput("t6_stall_sent", sent, 4);
    checkOutput("t6_head_valid", rready, 1);
    checkOutput("t6_head_cmd", rcmd, expResp[0]);
    rack   = 1'b1;
    anyErr = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (sent < 8) begin
        wcmd   = {8'h00, 24'(sent), 32'h0};
        wvalid = 1'b1;
      end else begin
        wvalid = 1'b0;
      end
      canAccept = wvalid && wready;
      doPop     = rready;
      if (doPop) begin
        rxq.push_back(rcmd);
        anyErr = anyErr | rerr;
      end
      nextCycle();
      if (canAccept) sent++;
      if (doPop) got++;
    end
    rack   = 1'b0;
    wvalid = 1'b0;
    checkOutput("t6_rx_count", got, 8);
    checkOutput("t6_rx_err", anyErr, 0);
    for (int i = 0; i < 8; i++) begin
      if (i < rxq.size()) checkOutput($sformatf("t6_rx%0d", i), rxq[i], expResp[i]);
      else checkOutput($sformatf("t6_rx%0d_missing", i), 0, expResp[i]);
    end
    checkOutput("t6_empty", rready, 0);
    checkOutput("t6_wready_back", wready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
